// File: rtl/mac4621_acc33_pkg.sv
// Shared constants and types for the mod-4621 multiply-accumulate stage.
// Sized so the unreduced dot product feeds the 33-bit centered reducer directly.
package mac4621_acc33_pkg;

   localparam int NTRU_Q          = 4621;
   localparam int NTRU_QH         = 2310;
   localparam int COEF_W          = 13;
   localparam int PROD_W          = 26;
   localparam int ACC_W           = 33;
   localparam int CNT_W           = 10;
   localparam int MAX_TERMS_LIMIT = 804;   // floor((2^32-1) / 2310^2)

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_ACCUM = 1'b1
   } acc_state_e;

   function automatic logic signed [ACC_W-1:0] sext_prod(input logic signed [PROD_W-1:0] p);
      return {{(ACC_W-PROD_W){p[PROD_W-1]}}, p};
   endfunction

endpackage

// File: rtl/mac4621_mul.sv
// Two-stage registered 13x13 signed multiplier (S1 operand capture, S2 product),
// carrying the term's valid and last tags alongside the data.
module mac4621_mul
   import mac4621_acc33_pkg::*;
(
   input  logic                     clk,
   input  logic                     Reset,
   input  logic                     valid_i,
   input  logic                     last_i,
   input  logic signed [COEF_W-1:0] a_i,
   input  logic signed [COEF_W-1:0] b_i,
   output logic                     valid_o,
   output logic                     last_o,
   output logic signed [PROD_W-1:0] prod_o
);

   logic signed [COEF_W-1:0] a_q, b_q;
   logic                     v1_q, l1_q;
   logic signed [PROD_W-1:0] prod_q, prod_d;
   logic                     v2_q, l2_q;
   logic signed [PROD_W-1:0] a_x, b_x;

   // Operands are widened before multiplying; even -4096*-4096 fits in 26 bits.
   always_comb begin
      a_x    = {{(PROD_W-COEF_W){a_q[COEF_W-1]}}, a_q};
      b_x    = {{(PROD_W-COEF_W){b_q[COEF_W-1]}}, b_q};
      prod_d = a_x * b_x;
   end

   always_ff @(posedge clk) begin
      if (Reset) begin
         a_q    <= '0;
         b_q    <= '0;
         v1_q   <= 1'b0;
         l1_q   <= 1'b0;
         prod_q <= '0;
         v2_q   <= 1'b0;
         l2_q   <= 1'b0;
      end else begin
         a_q    <= a_i;
         b_q    <= b_i;
         v1_q   <= valid_i;
         l1_q   <= valid_i & last_i;
         prod_q <= prod_d;
         v2_q   <= v1_q;
         l2_q   <= l1_q;
      end
   end

   assign valid_o = v2_q;
   assign last_o  = l2_q;
   assign prod_o  = prod_q;

endmodule

// File: rtl/mac4621_acc33.sv
// Streaming signed dot-product accumulator for centered mod-4621 coefficients.
// state  | meaning
// IDLE   | no dot product open; next valid term loads the accumulator
// ACCUM  | dot product open; valid terms add until a last-tagged one emits
module mac4621_acc33
   import mac4621_acc33_pkg::*;
#(
   parameter int MAX_TERMS = 653
) (
   input  logic                     clk,
   input  logic                     Reset,
   input  logic                     in_valid,
   input  logic                     in_last,
   input  logic signed [COEF_W-1:0] in_a,
   input  logic signed [COEF_W-1:0] in_b,
   output logic                     out_valid,
   output logic signed [ACC_W-1:0]  out_sum,
   output logic [CNT_W-1:0]         out_count,
   output logic                     err_overflow
);

   if (MAX_TERMS < 1 || MAX_TERMS > MAX_TERMS_LIMIT) begin : g_bad_max_terms
      $error("mac4621_acc33: MAX_TERMS must be in 1..804");
   end

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_TERMS);

   logic                     s2_valid, s2_last;
   logic signed [PROD_W-1:0] s2_prod;

   mac4621_mul u_mul (
      .clk     (clk),
      .Reset   (Reset),
      .valid_i (in_valid),
      .last_i  (in_last),
      .a_i     (in_a),
      .b_i     (in_b),
      .valid_o (s2_valid),
      .last_o  (s2_last),
      .prod_o  (s2_prod)
   );

   acc_state_e              state_q;
   logic signed [ACC_W-1:0] acc_q, sum_d, prod_x;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    drop_d;
   logic                    out_valid_q, err_q;
   logic signed [ACC_W-1:0] out_sum_q;
   logic [CNT_W-1:0]        out_count_q;

   // A term past the limit is dropped: the running sum and count are carried unchanged.
   always_comb begin
      prod_x = sext_prod(s2_prod);
      drop_d = (state_q == ST_ACCUM) && (cnt_q == MAX_CNT);
      if (state_q == ST_IDLE) begin
         sum_d = prod_x;
         cnt_d = CNT_W'(1);
      end else if (drop_d) begin
         sum_d = acc_q;
         cnt_d = cnt_q;
      end else begin
         sum_d = acc_q + prod_x;
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (Reset) begin
         state_q     <= ST_IDLE;
         acc_q       <= '0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_sum_q   <= '0;
         out_count_q <= '0;
         err_q       <= 1'b0;
      end else begin
         out_valid_q <= 1'b0;
         if (s2_valid) begin
            if (drop_d) err_q <= 1'b1;
            if (s2_last) begin
               out_sum_q   <= sum_d;
               out_count_q <= cnt_d;
               out_valid_q <= 1'b1;
               state_q     <= ST_IDLE;
            end else begin
               acc_q   <= sum_d;
               cnt_q   <= cnt_d;
               state_q <= ST_ACCUM;
            end
         end
      end
   end

   assign out_valid    = out_valid_q;
   assign out_sum      = out_sum_q;
   assign out_count    = out_count_q;
   assign err_overflow = err_q;

endmodule

// File: tb/tb_mac4621_acc33.sv
// Directed bench for mac4621_acc33: a term-list model predicts each emitted dot
// product and its due cycle; a negedge monitor compares every cycle.
module tb_mac4621_acc33;

   localparam int MAXT = 653;

   logic               clk = 1'b0;
   logic               Reset = 1'b1;
   logic               in_valid = 1'b0;
   logic               in_last = 1'b0;
   logic signed [12:0] in_a = '0;
   logic signed [12:0] in_b = '0;
   logic               out_valid;
   logic signed [32:0] out_sum;
   logic [9:0]         out_count;
   logic               err_overflow;

   mac4621_acc33 #(.MAX_TERMS(MAXT)) dut (
      .clk          (clk),
      .Reset        (Reset),
      .in_valid     (in_valid),
      .in_last      (in_last),
      .in_a         (in_a),
      .in_b         (in_b),
      .out_valid    (out_valid),
      .out_sum      (out_sum),
      .out_count    (out_count),
      .err_overflow (err_overflow)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int     due;
      longint sum;
      int     cnt;
      bit     err;
   } exp_t;

   exp_t   q[$];
   longint obs_sum[$];
   int     obs_cnt[$];
   int     last_emit_cyc = -1;
   bit     mon_en = 1'b0;

   int     m_n = 0;
   longint m_sum = 0;
   bit     m_sticky = 1'b0;

   int n_chk = 0;
   int n_pass = 0;

   function automatic void chk(string nm, longint act, longint want);
      n_chk++;
      if (act == want) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, want, cyc);
   endfunction

   // Model: a dot product is the list of its first MAXT terms; extra terms only flag.
   task automatic term(int a, int b, bit last, bit valid = 1'b1);
      @(negedge clk); #1;
      in_valid = valid;
      in_last  = last;
      in_a     = 13'(a);
      in_b     = 13'(b);
      if (valid) begin
         if (m_n < MAXT) begin
            m_sum += longint'(a) * longint'(b);
            m_n++;
         end else begin
            m_sticky = 1'b1;
         end
         if (last) begin
            q.push_back('{cyc + 3, m_sum, m_n, m_sticky});
            m_n   = 0;
            m_sum = 0;
         end
      end
   endtask

   task automatic idle(int n);
      repeat (n) term(0, 0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge clk); #1;
      Reset    = 1'b1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      q.delete();
      m_n      = 0;
      m_sum    = 0;
      m_sticky = 1'b0;
      @(negedge clk); #1;
      Reset = 1'b0;
   endtask

   task automatic clear_obs();
      obs_sum.delete();
      obs_cnt.delete();
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         bit e;
         while (q.size() > 0 && q[0].due < cyc) begin
            chk("missed_emit_cycle", cyc, q[0].due);
            void'(q.pop_front());
         end
         e = (q.size() > 0 && q[0].due == cyc);
         chk("out_valid", longint'(out_valid), longint'(e));
         if (out_valid) begin
            obs_sum.push_back(longint'(out_sum));
            obs_cnt.push_back(int'(out_count));
            last_emit_cyc = cyc;
         end
         if (e) begin
            if (out_valid) begin
               chk("out_sum", longint'(out_sum), q[0].sum);
               chk("out_count", longint'(out_count), longint'(q[0].cnt));
               chk("err_at_emit", longint'(err_overflow), longint'(q[0].err));
            end
            void'(q.pop_front());
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      int t0;
      repeat (2) @(negedge clk);
      mon_en = 1'b1;
      chk("rst_out_valid", longint'(out_valid), 0);
      chk("rst_out_sum", longint'(out_sum), 0);
      chk("rst_out_count", longint'(out_count), 0);
      chk("rst_err", longint'(err_overflow), 0);
      #1 Reset = 1'b0;

      // single full-scale term, latency 3
      clear_obs();
      term(2310, 2310, 1'b1);
      t0 = cyc;
      idle(5);
      chk("t1_n_emit", obs_sum.size(), 1);
      if (obs_sum.size() >= 1) begin
         chk("t1_sum", obs_sum[0], 5336100);
         chk("t1_cnt", obs_cnt[0], 1);
      end
      chk("t1_latency", last_emit_cyc - t0, 3);
      chk("t1_held_sum", longint'(out_sum), 5336100);

      // 653 negative full-scale terms
      clear_obs();
      for (int i = 0; i < 653; i++) term(-2310, 2310, i == 652);
      idle(5);
      chk("t2_n_emit", obs_sum.size(), 1);
      if (obs_sum.size() >= 1) begin
         chk("t2_sum", obs_sum[0], -64'sd3484473300);
         chk("t2_cnt", obs_cnt[0], 653);
      end
      chk("t2_err", longint'(err_overflow), 0);

      // back-to-back dot products, plus a last without valid
      clear_obs();
      term(3, 4, 1'b0);
      term(5, 6, 1'b1);
      term(-7, 8, 1'b1);
      term(9, 9, 1'b1, 1'b0);
      idle(5);
      chk("t3_n_emit", obs_sum.size(), 2);
      if (obs_sum.size() >= 2) begin
         chk("t3_sum0", obs_sum[0], 42);
         chk("t3_cnt0", obs_cnt[0], 2);
         chk("t3_sum1", obs_sum[1], -56);
         chk("t3_cnt1", obs_cnt[1], 1);
      end

      // bubbles inside a dot product
      clear_obs();
      term(1, 1, 1'b0); idle(2);
      term(2, 2, 1'b0); idle(2);
      term(3, 3, 1'b1);
      idle(5);
      chk("t4_n_emit", obs_sum.size(), 1);
      if (obs_sum.size() >= 1) begin
         chk("t4_sum", obs_sum[0], 14);
         chk("t4_cnt", obs_cnt[0], 3);
      end

      // term limit: 655 terms saturate at 653, sticky error
      clear_obs();
      for (int i = 0; i < 655; i++) term(1, 1, i == 654);
      idle(5);
      chk("t5_n_emit", obs_sum.size(), 1);
      if (obs_sum.size() >= 1) begin
         chk("t5_sum", obs_sum[0], 653);
         chk("t5_cnt", obs_cnt[0], 653);
      end
      chk("t5_err", longint'(err_overflow), 1);
      clear_obs();
      term(2, 2, 1'b1);
      idle(5);
      chk("t5_clean_n_emit", obs_sum.size(), 1);
      if (obs_sum.size() >= 1) chk("t5_clean_sum", obs_sum[0], 4);
      chk("t5_err_sticky", longint'(err_overflow), 1);

      // reset mid dot product discards partial sum and clears the flag
      clear_obs();
      for (int i = 0; i < 5; i++) term(100, 100, 1'b0);
      do_reset();
      term(2, 3, 1'b1);
      idle(5);
      chk("t6_n_emit", obs_sum.size(), 1);
      if (obs_sum.size() >= 1) begin
         chk("t6_sum", obs_sum[0], 6);
         chk("t6_cnt", obs_cnt[0], 1);
      end
      chk("t6_err_cleared", longint'(err_overflow), 0);

      // out-of-contract operands are multiplied as given
      clear_obs();
      term(-4096, 4095, 1'b1);
      idle(5);
      chk("t7_n_emit", obs_sum.size(), 1);
      if (obs_sum.size() >= 1) chk("t7_sum", obs_sum[0], -16773120);

      chk("pending_expected", q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/mac4621_acc33.md
# mac4621_acc33

Streaming multiply-accumulate stage that forms signed dot products of centered mod-4621 coefficients and emits each unreduced sum as a 33-bit signed word. It sits directly upstream of the 33-bit centered mod-4621 reduction pipeline in the NTRU Prime (q = 4621) polynomial-multiply datapath. Its output width and range are chosen so the reducer needs no pre-scaling.

## Interface
- MAX_TERMS, 653, maximum number of terms per dot product; legal range 1..804, where 804 = floor((2^32−1)/2310²).
- clk  in  1  clock
- Reset  in  1  synchronous, active-high
- in_valid  in  1  term present this cycle; no backpressure, so every valid term is accepted
- in_last  in  1  qualifies in_valid; marks the final term of the current dot product
- in_a  in  13  signed coefficient, contract range −2310..2310
- in_b  in  13  signed coefficient, contract range −2310..2310
- out_valid  out  1  one-cycle pulse when a completed sum is presented
- out_sum  out  33  signed dot product; held between pulses
- out_count  out  10  number of terms accumulated into out_sum; held between pulses
- err_overflow  out  1  sticky; a dot product exceeded MAX_TERMS

## Operation
- Pipeline: S1 registers a, b, valid, last. S2 registers the 26-bit signed product a·b, plus valid and last. S3 is the accumulator.
- Accumulator FSM, states IDLE and ACCUM, advances only on S2 valid:
  - IDLE + valid + !last: acc ← prod, cnt ← 1, go to ACCUM.
  - IDLE + valid + last: emit prod with count 1, stay in IDLE.
  - ACCUM + valid + !last: acc ← acc + prod, cnt ← cnt + 1.
  - ACCUM + valid + last: emit acc + prod with count cnt + 1, go to IDLE.
  - S2 invalid (bubble): no change in either state.
- Emit means: out_sum ← sum (sign-extended to 33 bits), out_count ← count, out_valid ← 1 for one cycle.
- Back-to-back dot products need no idle cycle. The term after a last-tagged term loads the accumulator; it is not added to the previous sum.
- Term limit:
  - A term that would make count exceed MAX_TERMS is dropped: not added, cnt saturates at MAX_TERMS.
  - The dropped term sets err_overflow. It stays set until Reset.
  - A dropped term tagged last still closes the dot product and emits the saturated sum.
- Width: |sum| ≤ 804·5,336,100 < 2^32, so 33-bit signed arithmetic never wraps. The accumulator is exactly 33 bits.
- Out-of-contract operands (|a| or |b| > 2310) are multiplied as given. Range is not guaranteed in that case, and no flag is raised.
- in_last without in_valid is ignored.

## Timing
- Latency: a last-tagged term at cycle t produces out_valid at t+3.
- Throughput: one term per cycle; up to one out_valid per cycle, for consecutive single-term dot products.
- Reset values: out_valid 0, out_sum 0, out_count 0, err_overflow 0, FSM IDLE, all pipeline valids 0.
- Reset mid-operation:
  - In-flight terms and the partial sum are discarded, with no out_valid.
  - The first valid term after Reset deasserts starts a new dot product.
- Reset has priority over all other events in the same cycle.

## Structure
- Shared package holds the constants:
  - NTRU_Q = 4621, NTRU_QH = 2310
  - COEF_W = 13, PROD_W = 26, ACC_W = 33
  - MAX_TERMS_LIMIT = 804
- One sub-module, mac4621_mul: the registered 13×13 signed multiplier, i.e. stages S1–S2 carrying valid and last. The FSM and accumulator stay in the top module.
- An elaboration-time check rejects MAX_TERMS outside 1..804.

## Test plan
- Single term a = 2310, b = 2310, last, at cycle 0 → out_valid at cycle 3, out_sum 5,336,100, out_count 1.
- 653 terms of a = −2310, b = 2310, last on the final term → out_sum −3,484,473,300, out_count 653, err_overflow 0.
- Terms (3,4) at cycle 0, (5,6, last) at cycle 1, (−7,8, last) at cycle 2 → out_sum 42 with count 2 at cycle 4, then −56 with count 1 at cycle 5.
- Terms (1,1), (2,2), (3,3, last) with 2-cycle bubbles between terms → single out_valid, out_sum 14, out_count 3.
- With MAX_TERMS = 653, 655 terms of (1,1) with the final one last → out_sum 653, out_count 653, err_overflow 1 and still 1 after a later clean dot product.
- Five terms of (100,100), then Reset for one cycle, then (2,3, last) → no out_valid for the aborted dot product; out_sum 6, out_count 1.
